// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a word-addressed register memory, with configurable wait states.
// Supports byte/halfword/word accesses and two-cycle ERROR responses.
module ahb_slave_mem #(
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  // state | meaning
  // IDLE  | ready; also the completion cycle of an OKAY transfer when dphase_q=1
  // WAIT  | OKAY transfer stalled, cnt_q counts remaining low cycles down to 0
  // ERR1  | first ERROR cycle, HREADYOUT low
  // ERR2  | second ERROR cycle, HREADYOUT high, may accept next transfer
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_e;

  localparam int IDX_W = $clog2(MEM_DEPTH);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               dphase_q, dphase_d;
  logic               write_q, write_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         lane_q, lane_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic               accept;
  logic               xfer_err;
  logic               commit;
  logic [3:0]         byte_en;
  logic [31:0]        rd_word;
  logic [31:0]        wr_word;
  logic [31:0]        mem_w [MEM_DEPTH];

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign xfer_err = (HADDR[31:2] >= 30'(MEM_DEPTH))
                  | (HSIZE > 3'd2)
                  | ((HSIZE == 3'd1) & HADDR[0])
                  | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dphase_d = dphase_q;
    write_d  = write_q;
    size_d   = size_q;
    lane_d   = lane_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE, ERR2: begin
        state_d  = IDLE;
        dphase_d = 1'b0;
        cnt_d    = 4'd0;
        if (accept) begin
          write_d = HWRITE;
          size_d  = HSIZE[1:0];
          lane_d  = HADDR[1:0];
          idx_d   = HADDR[IDX_W+1:2];
          if (xfer_err) begin
            state_d = ERR1;
          end else begin
            dphase_d = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = WAIT;
              cnt_d   = 4'(WAIT_STATES - 1);
            end
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      dphase_q <= 1'b0;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      lane_q   <= 2'd0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dphase_q <= dphase_d;
      write_q  <= write_d;
      size_q   <= size_d;
      lane_q   <= lane_d;
      idx_q    <= idx_d;
    end
  end

  // Completion cycle of an OKAY transfer is IDLE with a data phase still open.
  assign commit = dphase_q & write_q & (state_q == IDLE);

  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      2'd0:    byte_en = 4'b0001 << lane_q;
      2'd1:    byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  assign rd_word = mem_w[idx_q];

  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) wr_word[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  for (genvar w = 0; w < MEM_DEPTH; w++) begin : g_word
    logic [31:0] word_q;
    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)                              word_q <= 32'd0;
      else if (commit && (idx_q == IDX_W'(w)))   word_q <= wr_word;
    end
    assign mem_w[w] = word_q;
  end

  assign HREADYOUT = (state_q != WAIT) && (state_q != ERR1);
  assign HRESP     = (state_q == ERR1) || (state_q == ERR2);
  assign HRDATA    = (dphase_q && !write_q) ? rd_word : 32'd0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomised and directed bench for ahb_slave_mem: instance 0 runs with no wait states,
// instance 1 with one; a byte-addressed memory model predicts every response.
module tb_ahb_slave_mem;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          gap;
  } xfer_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n, hsel, hwrite, hmastlock, hready, hready_lo, hreadyout, hresp;
  logic [31:0] haddr [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];
  logic [2:0]  hsize [2];
  logic [2:0]  hburst [2];
  logic [1:0]  htrans [2];
  logic [3:0]  hprot [2];

  assign hready = hreadyout & ~hready_lo;

  ahb_slave_mem #(.MEM_DEPTH(64), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HBURST(hburst[0]), .HPROT(hprot[0]),
    .HMASTLOCK(hmastlock[0]), .HREADY(hready[0]), .HWDATA(hwdata[0]),
    .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

  ahb_slave_mem #(.MEM_DEPTH(64), .WAIT_STATES(1)) u_dut1 (
    .HCLK(clk), .HRESETn(rst_n[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HBURST(hburst[1]), .HPROT(hprot[1]),
    .HMASTLOCK(hmastlock[1]), .HREADY(hready[1]), .HWDATA(hwdata[1]),
    .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdl [2][64];
  logic [31:0] last_rdata;
  xfer_t       xq[$];

  function automatic int ws(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic bit is_err(input xfer_t x);
    return ((x.addr / 4) >= 64) || (x.size > 3'd2) ||
           ((x.size == 3'd1) && (x.addr % 2 != 0)) ||
           ((x.size == 3'd2) && (x.addr % 4 != 0));
  endfunction

  function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                               input logic [31:0] d, input int g = 0);
    xfer_t x;
    x.addr = a; x.wr = w; x.size = s; x.wdata = d; x.gap = g;
    return x;
  endfunction

  // Byte-address view: each addressed byte takes the HWDATA lane it sits on.
  task automatic mdl_write(input int k, input xfer_t x);
    int n;
    n = 1 << x.size;
    for (int i = 0; i < n; i++) begin
      int a;
      a = int'(x.addr) + i;
      mdl[k][a / 4][8*(a % 4) +: 8] = x.wdata[8*(a % 4) +: 8];
    end
  endtask

  task automatic bus_idle(input int k);
    hsel[k]   = 1'b0;
    htrans[k] = 2'd0;
    hwrite[k] = 1'b0;
    hsize[k]  = 3'd0;
    haddr[k]  = $urandom;
    hburst[k] = 3'($urandom);
    hprot[k]  = 4'($urandom);
    hmastlock[k] = 1'($urandom);
  endtask

  task automatic clear_model(input int k);
    for (int i = 0; i < 64; i++) mdl[k][i] = 32'd0;
  endtask

  // Pipelined master: address of the next transfer overlaps the data phase of the current one.
  task automatic run_xfers(input int k);
    int    ap, waits, budget, gap;
    bit    have_dp, ready, e;
    xfer_t d;
    logic [31:0] exp_d;
    ap = 0; waits = 0; budget = 0; have_dp = 0;
    gap = (xq.size() > 0) ? xq[0].gap : 0;
    while ((ap < xq.size() || have_dp) && budget < 500) begin
      if (have_dp) hwdata[k] = d.wdata;
      else         hwdata[k] = $urandom;
      if (ap < xq.size() && gap == 0) begin
        hsel[k] = 1'b1; htrans[k] = 2'd2; haddr[k] = xq[ap].addr;
        hwrite[k] = xq[ap].wr; hsize[k] = xq[ap].size;
      end else begin
        bus_idle(k);
        hsel[k] = 1'($urandom);
      end
      ready = hreadyout[k];
      if (have_dp) begin
        e = is_err(d);
        if (!ready) begin
          waits++;
          checks++;
          if (hresp[k] !== e) begin
            errors++;
            $display("FAIL wait_resp k=%0d addr=%h: got %b expected %b", k, d.addr, hresp[k], e);
          end
          if (e || !d.wr) begin
            exp_d = e ? 32'd0 : mdl[k][d.addr / 4];
            checks++;
            if (hrdata[k] !== exp_d) begin
              errors++;
              $display("FAIL wait_rdata k=%0d addr=%h: got %h expected %h", k, d.addr, hrdata[k], exp_d);
            end
          end
        end else begin
          checks++;
          if (waits != (e ? 1 : ws(k))) begin
            errors++;
            $display("FAIL wait_count k=%0d addr=%h: got %0d expected %0d", k, d.addr, waits, e ? 1 : ws(k));
          end
          checks++;
          if (hresp[k] !== e) begin
            errors++;
            $display("FAIL done_resp k=%0d addr=%h: got %b expected %b", k, d.addr, hresp[k], e);
          end
          if (e || !d.wr) begin
            exp_d = e ? 32'd0 : mdl[k][d.addr / 4];
            checks++;
            if (hrdata[k] !== exp_d) begin
              errors++;
              $display("FAIL rdata k=%0d addr=%h: got %h expected %h", k, d.addr, hrdata[k], exp_d);
            end
          end
          if (!e && d.wr) mdl_write(k, d);
          last_rdata = hrdata[k];
          have_dp = 0;
        end
      end
      if (ready && ap < xq.size()) begin
        if (gap > 0) gap--;
        else begin
          d = xq[ap];
          have_dp = 1;
          waits = 0;
          ap++;
          gap = (ap < xq.size()) ? xq[ap].gap : 0;
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    checks++;
    if (budget >= 500) begin
      errors++;
      $display("FAIL timeout k=%0d: got %0d cycles expected fewer than 500", k, budget);
    end
    bus_idle(k);
    xq.delete();
  endtask

  task automatic check_quiet(input int k, input string nm);
    checks++;
    if (hreadyout[k] !== 1'b1) begin
      errors++; $display("FAIL %s_hreadyout k=%0d: got %b expected 1", nm, k, hreadyout[k]);
    end
    checks++;
    if (hresp[k] !== 1'b0) begin
      errors++; $display("FAIL %s_hresp k=%0d: got %b expected 0", nm, k, hresp[k]);
    end
    checks++;
    if (hrdata[k] !== 32'd0) begin
      errors++; $display("FAIL %s_hrdata k=%0d: got %h expected 0", nm, k, hrdata[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      bus_idle(k);
      hwdata[k] = 32'd0;
      hready_lo[k] = 1'b0;
      clear_model(k);
    end
    @(posedge clk); #1;
    check_quiet(0, "reset");
    check_quiet(1, "reset");
    rst_n = 2'b11;
    // Reset asserted in the middle of a stalled read on the wait-state instance.
    xq.push_back(mk(32'h04, 1'b1, 3'd2, 32'h1234_5678));
    run_xfers(1);
    hsel[1] = 1'b1; htrans[1] = 2'd2; haddr[1] = 32'h04; hwrite[1] = 1'b0; hsize[1] = 3'd2;
    @(posedge clk); #1;
    checks++;
    if (hreadyout[1] !== 1'b0) begin
      errors++; $display("FAIL midwait_stall: got %b expected 0", hreadyout[1]);
    end
    checks++;
    if (hrdata[1] !== 32'h1234_5678) begin
      errors++; $display("FAIL midwait_rdata: got %h expected 12345678", hrdata[1]);
    end
    bus_idle(1);
    rst_n[1] = 1'b0;
    #1;
    check_quiet(1, "midwait_reset");
    clear_model(1);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    xq.push_back(mk(32'h04, 1'b0, 3'd2, 32'h0));
    run_xfers(1);
    checks++;
    if (last_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_read04: got %h expected 0", last_rdata);
    end
  endtask

  task automatic test_wait_states();
    xq.push_back(mk(32'h04, 1'b1, 3'd2, 32'hAABB_CCDD));
    xq.push_back(mk(32'h04, 1'b0, 3'd2, 32'h0));
    run_xfers(1);
    checks++;
    if (last_rdata !== 32'hAABB_CCDD) begin
      errors++; $display("FAIL ws1_read04: got %h expected aabbccdd", last_rdata);
    end
    xq.push_back(mk(32'h05, 1'b1, 3'd0, 32'h0000_EE00));
    xq.push_back(mk(32'h04, 1'b0, 3'd2, 32'h0));
    run_xfers(1);
    checks++;
    if (last_rdata !== 32'hAABB_EEDD) begin
      errors++; $display("FAIL byte_merge: got %h expected aabbeedd", last_rdata);
    end
  endtask

  task automatic test_error();
    xq.push_back(mk(32'h00, 1'b1, 3'd2, 32'h1122_3344));
    xq.push_back(mk(32'h02, 1'b1, 3'd2, 32'hFFFF_FFFF));
    xq.push_back(mk(32'h00, 1'b0, 3'd2, 32'h0));
    run_xfers(1);
    checks++;
    if (last_rdata !== 32'h1122_3344) begin
      errors++; $display("FAIL err_untouched: got %h expected 11223344", last_rdata);
    end
  endtask

  task automatic test_back_to_back();
    xq.push_back(mk(32'h08, 1'b1, 3'd2, 32'hAABB_CCDD));
    xq.push_back(mk(32'h0C, 1'b1, 3'd2, 32'hABCD_EF00));
    xq.push_back(mk(32'h0C, 1'b0, 3'd2, 32'h0));
    run_xfers(0);
    checks++;
    if (last_rdata !== 32'hABCD_EF00) begin
      errors++; $display("FAIL b2b_read0c: got %h expected abcdef00", last_rdata);
    end
  endtask

  task automatic test_hready_low();
    hsel[0] = 1'b1; htrans[0] = 2'd2; haddr[0] = 32'h10; hwrite[0] = 1'b1; hsize[0] = 3'd2;
    hready_lo[0] = 1'b1;
    @(posedge clk); #1;
    hwdata[0] = 32'hDEAD_BEEF;
    bus_idle(0);
    hready_lo[0] = 1'b0;
    check_quiet(0, "hready_low");
    @(posedge clk); #1;
    xq.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0));
    run_xfers(0);
    checks++;
    if (last_rdata !== 32'd0) begin
      errors++; $display("FAIL hready_low_read10: got %h expected 0", last_rdata);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 60; n++) begin
        logic [31:0] a;
        logic [2:0]  s;
        s = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
        if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(256, 4095));
        if ($urandom_range(0, 19) == 0) a = a | 32'h8000_0000;
        xq.push_back(mk(a, 1'($urandom), s, $urandom,
                        ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0));
      end
      run_xfers(k);
    end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_error();
    test_back_to_back();
    test_hready_low();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
